cordic_scheduler: RTL and testbench
===================================

Name: cordic_scheduler

Overview:
- Shares one iterative CORDIC core between two requesters (A, B) with round-robin arbitration.
- Per operation: accepts operands over valid/ready, pulses the core's init for one cycle, counts ITERATIONS core cycles, captures the core outputs and returns them over a valid/ready result port tagged with the requester id.
- Sits between the client logic and the core; the core itself is unchanged.

Parameters:
- WIDTH, 17, datapath width of x/y/z.
- ITERATIONS, 16, rotation cycles per operation; legal range 1..16.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_ni  in  1  reset, asynchronous, active-low.
- a_valid_i  in  1  requester A operand valid.
- a_ready_o  out  1  requester A operand accepted.
- a_x_i, a_y_i, a_z_i  in  WIDTH each  requester A operands.
- b_valid_i  in  1  requester B operand valid.
- b_ready_o  out  1  requester B operand accepted.
- b_x_i, b_y_i, b_z_i  in  WIDTH each  requester B operands.
- core_init_o  out  1  init strobe to the core.
- core_x_o, core_y_o, core_z_o  out  WIDTH each  operands driven to the core.
- core_x_i, core_y_i, core_z_i  in  WIDTH each  core result outputs.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  result consumer ready.
- res_id_o  out  1  0 = requester A, 1 = requester B.
- res_x_o, res_y_o, res_z_o  out  WIDTH each  captured result.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, LOAD, RUN, DONE.
- Reset (reset_ni low, asynchronous):
  - state = IDLE; last_grant = 1, so A wins the first contention.
  - iteration counter = 0.
  - Operand, result and id registers = 0.
  - All outputs = 0: res_valid_o, core_init_o, busy_o, a_ready_o, b_ready_o.
- IDLE:
  - grant_a = a_valid_i and (not b_valid_i or last_grant == 1).
  - grant_b = b_valid_i and not grant_a.
  - a_ready_o = grant_a and b_ready_o = grant_b, both combinational and asserted only in IDLE.
  - On the accepting edge: latch the granted operands and id, update last_grant to the granted id, go to LOAD.
  - A single valid requester is always granted regardless of last_grant.
- LOAD (exactly 1 cycle):
  - core_init_o = 1; core_x_o/core_y_o/core_z_o = latched operands (driven from registers in every state).
  - Counter cleared to 0; go to RUN.
- RUN:
  - core_init_o = 0; counter increments each cycle.
  - On the edge where counter == ITERATIONS-1: capture core_x_i/core_y_i/core_z_i into the result registers, set res_valid_o, go to DONE.
- DONE:
  - res_valid_o held high; res_* and res_id_o stable until res_valid_o and res_ready_i are both high on a clock edge.
  - On that handshake edge: clear res_valid_o, go to IDLE.
  - No new operand is accepted while in DONE.
- Latency: res_valid_o rises ITERATIONS+2 cycles after the accepting edge; minimum throughput is one operation per ITERATIONS+3 cycles.
- res_ready_i already high when res_valid_o rises: DONE lasts exactly 1 cycle.
- Back-pressure: while res_ready_i is held low, the block stays in DONE indefinitely with outputs frozen.
- Requester valids asserted outside IDLE are ignored; ready stays 0.
- Reset mid-operation: immediate return to IDLE with all reset values; no partial result is ever presented.
- Widths: the counter is 5 bits wide; operands and results pass through unmodified (no arithmetic in this block).

Test Plan:
- Bench core: a stub model with core outputs = operands + iteration index.
- Single A op, ITERATIONS=16:
  - Stimulus: a_x=100, a_y=200, a_z=300.
  - Response: a_ready_o is 1 for one cycle; core_init_o pulses 1 cycle later; res_valid_o rises 18 cycles after acceptance with res_id_o=0 and res values equal to the stub outputs at the capture edge.
- Simultaneous A and B valid from reset:
  - Order: A granted first (res_id_o=0), then B (res_id_o=1).
  - Repeating both requests gives the grant order A, B, A, B.
- Back-pressure:
  - Stimulus: hold res_ready_i=0 for 10 cycles after res_valid_o.
  - Response: res_* stable, busy_o=1, b_ready_o=0 despite b_valid_i=1; B is accepted on the cycle after the handshake.
- Reset mid-operation:
  - Stimulus: drop reset_ni at RUN counter=7.
  - Response: all outputs 0 asynchronously; after release, A and B contention grants A; no stale res_valid_o.
- ITERATIONS=1 build:
  - Response: res_valid_o at acceptance+3 cycles.
  - Back-to-back ops with res_ready_i tied high sustain one op per 4 cycles.

Source files
------------

// File: rtl/cordic_scheduler.sv
// Round-robin front end that shares one iterative CORDIC core between two
// requesters: accept operands, strobe init, count iterations, hand back the result.
module cordic_scheduler #(
  parameter int WIDTH      = 17,
  parameter int ITERATIONS = 16
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             a_valid_i,
  output logic             a_ready_o,
  input  logic [WIDTH-1:0] a_x_i,
  input  logic [WIDTH-1:0] a_y_i,
  input  logic [WIDTH-1:0] a_z_i,
  input  logic             b_valid_i,
  output logic             b_ready_o,
  input  logic [WIDTH-1:0] b_x_i,
  input  logic [WIDTH-1:0] b_y_i,
  input  logic [WIDTH-1:0] b_z_i,
  output logic             core_init_o,
  output logic [WIDTH-1:0] core_x_o,
  output logic [WIDTH-1:0] core_y_o,
  output logic [WIDTH-1:0] core_z_o,
  input  logic [WIDTH-1:0] core_x_i,
  input  logic [WIDTH-1:0] core_y_i,
  input  logic [WIDTH-1:0] core_z_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic             res_id_o,
  output logic [WIDTH-1:0] res_x_o,
  output logic [WIDTH-1:0] res_y_o,
  output logic [WIDTH-1:0] res_z_o,
  output logic             busy_o,
  output logic [1:0]       dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid must stay high with stable data until that edge.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [4:0] LAST_ITER = 5'(ITERATIONS - 1);

  logic [1:0]       state;
  logic             last_grant;
  logic             id_q;
  logic [4:0]       iter_cnt;
  logic [WIDTH-1:0] op_x, op_y, op_z;
  logic [WIDTH-1:0] res_x, res_y, res_z;
  logic             grant_a, grant_b;

  // last_grant == 1 means B was served last, so A has priority next.
  always_comb begin
    grant_a = reset_ni && (state == IDLE) && a_valid_i && (!b_valid_i || last_grant);
    grant_b = reset_ni && (state == IDLE) && b_valid_i && !grant_a;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      iter_cnt   <= 5'd0;
      op_x       <= '0;
      op_y       <= '0;
      op_z       <= '0;
      res_x      <= '0;
      res_y      <= '0;
      res_z      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_a || grant_b) begin
            op_x       <= grant_a ? a_x_i : b_x_i;
            op_y       <= grant_a ? a_y_i : b_y_i;
            op_z       <= grant_a ? a_z_i : b_z_i;
            id_q       <= grant_b;
            last_grant <= grant_b;
            state      <= LOAD;
          end
        end
        LOAD: begin
          iter_cnt <= 5'd0;
          state    <= RUN;
        end
        RUN: begin
          iter_cnt <= iter_cnt + 5'd1;
          if (iter_cnt == LAST_ITER) begin
            res_x <= core_x_i;
            res_y <= core_y_i;
            res_z <= core_z_i;
            state <= DONE;
          end
        end
        DONE: begin
          if (res_ready_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign a_ready_o   = grant_a;
  assign b_ready_o   = grant_b;
  assign core_init_o = (state == LOAD);
  assign core_x_o    = op_x;
  assign core_y_o    = op_y;
  assign core_z_o    = op_z;
  assign res_valid_o = (state == DONE);
  assign res_id_o    = id_q;
  assign res_x_o     = res_x;
  assign res_y_o     = res_y;
  assign res_z_o     = res_z;
  assign busy_o      = (state != IDLE);
  assign dbg_state_o = state;

endmodule

// File: tb/tb_cordic_scheduler.sv
// Bench for cordic_scheduler: stub core (operands + iteration index), a cycle
// countdown reference model with an expected-result queue, tables and random traffic.
module tb_cordic_scheduler;
  localparam int W    = 17;
  localparam int ITER = 16;
  localparam int RW   = 1 + 3 * W;

  logic         clk_i, rst_n;
  logic         a_valid, a_ready, b_valid, b_ready;
  logic [W-1:0] a_x, a_y, a_z, b_x, b_y, b_z;
  logic         core_init;
  logic [W-1:0] core_xo, core_yo, core_zo, core_xi, core_yi, core_zi;
  logic         res_valid, res_ready, res_id, busy;
  logic [W-1:0] res_x, res_y, res_z;
  logic [1:0]   dbg_state;

  // second instance built with a single iteration
  logic         a1_valid, a1_ready, b1_ready, core1_init, res1_valid, res1_id, busy1;
  logic [W-1:0] core1_xo, core1_yo, core1_zo, core1_xi, core1_yi, core1_zi;
  logic [W-1:0] res1_x, res1_y, res1_z;
  logic [1:0]   dbg1_state;

  int total = 0;
  int bad   = 0;

  cordic_scheduler #(.WIDTH(W), .ITERATIONS(ITER)) u_dut (
    .clk_i(clk_i), .reset_ni(rst_n),
    .a_valid_i(a_valid), .a_ready_o(a_ready), .a_x_i(a_x), .a_y_i(a_y), .a_z_i(a_z),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_x_i(b_x), .b_y_i(b_y), .b_z_i(b_z),
    .core_init_o(core_init), .core_x_o(core_xo), .core_y_o(core_yo), .core_z_o(core_zo),
    .core_x_i(core_xi), .core_y_i(core_yi), .core_z_i(core_zi),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_id_o(res_id),
    .res_x_o(res_x), .res_y_o(res_y), .res_z_o(res_z), .busy_o(busy),
    .dbg_state_o(dbg_state)
  );

  cordic_scheduler #(.WIDTH(W), .ITERATIONS(1)) u_dut1 (
    .clk_i(clk_i), .reset_ni(rst_n),
    .a_valid_i(a1_valid), .a_ready_o(a1_ready), .a_x_i(17'd11), .a_y_i(17'd12), .a_z_i(17'd13),
    .b_valid_i(1'b0), .b_ready_o(b1_ready), .b_x_i(17'd0), .b_y_i(17'd0), .b_z_i(17'd0),
    .core_init_o(core1_init), .core_x_o(core1_xo), .core_y_o(core1_yo), .core_z_o(core1_zo),
    .core_x_i(core1_xi), .core_y_i(core1_yi), .core_z_i(core1_zi),
    .res_valid_o(res1_valid), .res_ready_i(1'b1), .res_id_o(res1_id),
    .res_x_o(res1_x), .res_y_o(res1_y), .res_z_o(res1_z), .busy_o(busy1),
    .dbg_state_o(dbg1_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stub cores ----------------
  logic [W-1:0] iter_idx, iter1_idx;
  always @(posedge clk_i) begin
    iter_idx  <= core_init  ? '0 : iter_idx + 1'b1;
    iter1_idx <= core1_init ? '0 : iter1_idx + 1'b1;
  end
  assign core_xi  = core_xo + iter_idx;
  assign core_yi  = core_yo + iter_idx;
  assign core_zi  = core_zo + iter_idx;
  assign core1_xi = core1_xo + iter1_idx;
  assign core1_yi = core1_yo + iter1_idx;
  assign core1_zi = core1_zo + iter1_idx;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] ref_res(input logic id, input logic [W-1:0] x,
                                            input logic [W-1:0] y, input logic [W-1:0] z);
    logic [W-1:0] k;
    k = W'(ITER - 1);
    return {id, x + k, y + k, z + k};
  endfunction

  // ---------------- reference model / scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] got_q[$];
  bit  m_busy = 0;
  bit  m_last = 1;
  int  m_wait = 0;
  bit  acc_a = 0, acc_b = 0;
  bit  ga, gb;

  always @(negedge clk_i) begin
    acc_a = a_valid && a_ready;
    acc_b = b_valid && b_ready;
    if (!rst_n) begin
      m_busy = 0;
      m_last = 1;
      exp_q.delete();
      chk("rst_outputs", {a_ready, b_ready, core_init, res_valid, busy, res_id, dbg_state}, 0);
      chk("rst_data", {res_x, res_y, res_z, core_xo, core_yo, core_zo}, 0);
    end else if (!m_busy) begin
      ga = a_valid && (!b_valid || m_last);
      gb = b_valid && !ga;
      chk("a_ready", a_ready, ga);
      chk("b_ready", b_ready, gb);
      chk("idle_flags", {busy, res_valid, core_init}, 0);
      if (ga || gb) begin
        m_busy = 1;
        m_wait = ITER + 2;
        m_last = gb;
        exp_q.push_back(gb ? ref_res(1'b1, b_x, b_y, b_z) : ref_res(1'b0, a_x, a_y, a_z));
      end
    end else begin
      m_wait--;
      chk("busy_no_ready", {busy, a_ready, b_ready}, 3'b100);
      chk("core_init", core_init, m_wait == ITER + 1);
      if (m_wait <= 0) begin
        chk("res_valid", res_valid, 1);
        chk("res_data", {res_id, res_x, res_y, res_z}, exp_q[0]);
        if (res_ready) begin
          got_q.push_back({res_id, res_x, res_y, res_z});
          void'(exp_q.pop_front());
          m_busy = 0;
        end
      end else begin
        chk("res_valid_early", res_valid, 0);
      end
    end
  end

  // ITERATIONS=1 instance: latency and throughput with ready tied high
  bit en1 = 0;
  int cyc = 0, last_acc = -1, n1 = 0;
  always @(negedge clk_i) begin
    cyc++;
    if (en1 && rst_n) begin
      if (a1_ready) begin
        if (last_acc >= 0) chk("it1_period", cyc - last_acc, 4);
        last_acc = cyc;
        n1++;
      end
      if (res1_valid) begin
        chk("it1_latency", cyc - last_acc, 3);
        chk("it1_res", {res1_id, res1_x, res1_y, res1_z}, {1'b0, 17'd11, 17'd12, 17'd13});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
    if (acc_a) a_valid = 1'b0;
    if (acc_b) b_valid = 1'b0;
  endtask

  task automatic drain();
    int c;
    res_ready = 1'b1;
    for (c = 0; c < 200; c++) begin
      if (!a_valid && !b_valid && !busy) break;
      tick();
    end
    chk("drain_timeout", c < 200, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic av, bv;
    logic [W-1:0] ax, ay, az, bx, by, bz;
    int stall;
    int n;
    logic [RW-1:0] exp0;
    logic exp1_id;
    logic [W-1:0] exp1_x;
  } vec_t;
  vec_t tv[4];

  initial begin
    int sc, c;
    tv[0] = '{1'b1, 1'b1, 17'd100, 17'd200, 17'd300, 17'd1000, 17'd2000, 17'd3000, 0, 2,
              {1'b0, 17'd115, 17'd215, 17'd315}, 1'b1, 17'd1015};
    tv[1] = '{1'b1, 1'b1, 17'd7, 17'd8, 17'd9, 17'd0, 17'd0, 17'd0, 3, 2,
              {1'b0, 17'd22, 17'd23, 17'd24}, 1'b1, 17'd15};
    tv[2] = '{1'b0, 1'b1, 17'd0, 17'd0, 17'd0, 17'd5, 17'd6, 17'd7, 10, 1,
              {1'b1, 17'd20, 17'd21, 17'd22}, 1'b0, 17'd0};
    tv[3] = '{1'b1, 1'b0, 17'h1FFFF, 17'd0, 17'h1FFF0, 17'd0, 17'd0, 17'd0, 0, 1,
              {1'b0, 17'h0000E, 17'h0000F, 17'h1FFFF}, 1'b0, 17'd0};

    rst_n = 1'b0; a_valid = 0; b_valid = 0; a1_valid = 0; res_ready = 0;
    a_x = 0; a_y = 0; a_z = 0; b_x = 0; b_y = 0; b_z = 0;
    repeat (3) tick();
    chk("reset_state", {busy, res_valid, a_ready, dbg_state}, 0);
    rst_n = 1'b1;
    tick();

    // table-driven operations (first entry is A/B contention straight from reset)
    for (int i = 0; i < 4; i++) begin
      got_q.delete();
      a_x = tv[i].ax; a_y = tv[i].ay; a_z = tv[i].az;
      b_x = tv[i].bx; b_y = tv[i].by; b_z = tv[i].bz;
      a_valid = tv[i].av; b_valid = tv[i].bv;
      res_ready = 1'b0;
      sc = 0;
      for (c = 0; c < 200 && got_q.size() < tv[i].n; c++) begin
        tick();
        if (res_valid) sc++; else sc = 0;
        res_ready = (sc > tv[i].stall);
      end
      chk($sformatf("tv%0d_count", i), got_q.size(), tv[i].n);
      if (got_q.size() >= 1) chk($sformatf("tv%0d_first", i), got_q[0], tv[i].exp0);
      if (tv[i].n == 2 && got_q.size() == 2)
        chk($sformatf("tv%0d_second", i), {got_q[1][RW-1], got_q[1][RW-2 -: W]},
            {tv[i].exp1_id, tv[i].exp1_x});
      drain();
    end

    // back-pressure with B waiting while A's result is stalled
    a_x = 50; a_y = 60; a_z = 70; b_x = 9; b_y = 9; b_z = 9;
    res_ready = 1'b0;
    a_valid = 1'b1;
    for (c = 0; c < 20 && a_valid; c++) tick();
    b_valid = 1'b1;
    for (c = 0; c < 40 && !res_valid; c++) tick();
    chk("bp_valid_seen", res_valid, 1);
    for (int k = 0; k < 10; k++) begin
      chk("bp_b_ready", b_ready, 0);
      chk("bp_busy", busy, 1);
      chk("bp_res", {res_id, res_x, res_y, res_z}, {1'b0, 17'd65, 17'd75, 17'd85});
      tick();
    end
    res_ready = 1'b1;
    tick();
    chk("bp_b_accept_next", {res_valid, b_ready}, 2'b01);
    drain();

    // reset in the middle of RUN (counter = 7)
    a_x = 3; a_y = 3; a_z = 3;
    a_valid = 1'b1;
    for (c = 0; c < 20 && !core_init; c++) tick();
    chk("mr_init_seen", core_init, 1);
    repeat (8) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mr_async_clear", {res_valid, busy, core_init, a_ready, b_ready}, 0);
    chk("mr_async_data", {core_xo, res_x}, 0);
    a_valid = 1'b1; b_valid = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    chk("mr_grant_a", {a_ready, b_ready}, 2'b10);
    drain();

    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      tick();
      if (!a_valid && $urandom_range(0, 3) == 0) begin
        a_valid = 1'b1; a_x = W'($urandom); a_y = W'($urandom); a_z = W'($urandom);
      end
      if (!b_valid && $urandom_range(0, 3) == 0) begin
        b_valid = 1'b1; b_x = W'($urandom); b_y = W'($urandom); b_z = W'($urandom);
      end
      res_ready = 1'(($urandom_range(0, 1)));
    end
    drain();
    chk("exp_q_empty", exp_q.size(), 0);

    // single-iteration build, continuous requests
    en1 = 1'b1;
    a1_valid = 1'b1;
    repeat (40) tick();
    a1_valid = 1'b0;
    en1 = 1'b0;
    chk("it1_ops_enough", n1 >= 9, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
